// File: rtl/serial_addsub.sv
// serial_addsub
//   Multi-cycle adder/subtractor. It processes a WIDTH-bit add or subtract
//   DIGIT bits per clock through a chain of DIGIT full-adder cells. A
//   registered carry links one digit to the next.
//
//   Subtract is A + ~B + ~cin. The operand register holds ~B, and the
//   initial carry is cin ^ sub. When sub=1, cout=1 means no borrow occurred.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands and mode present
//   in_ready   block can accept operands (IDLE only)
//   a, b       WIDTH-bit operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0 = A+B+cin, 1 = A-B-cin
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   sum        WIDTH-bit result, modulo 2^WIDTH
//   cout       raw carry out of the MSB
//   overflow   two's-complement overflow
//
// Parameters
//   WIDTH >= 2. DIGIT must divide WIDTH exactly.
//   DIGIT == WIDTH gives a single RUN cycle.

module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] dig_top;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIGIT-1:0] dig_sum;
  logic             chain_cout;
  logic             msb_cin;
  logic             last_digit;
  logic             accept;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_digit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign last_digit = (state_q == RUN) && (cnt_q == LAST);

  // Ripple chain of DIGIT full-adder cells over the low operand bits.
  // The carry into the top cell is kept so that overflow can be formed
  // on the last digit, where that cell is bit WIDTH-1.
  always_comb begin
    logic c_ripple;
    c_ripple = carry_q;
    msb_cin  = 1'b0;
    dig_sum  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      dig_sum[i] = a_sr[i] ^ b_sr[i] ^ c_ripple;
      if (i == DIGIT - 1) begin
        msb_cin = c_ripple;
      end
      c_ripple = (a_sr[i] & b_sr[i]) | (c_ripple & (a_sr[i] ^ b_sr[i]));
    end
    chain_cout = c_ripple;
  end

  // New digit bits enter the result register from the MSB side.
  always_comb begin
    dig_top                    = '0;
    dig_top[WIDTH-1 -: DIGIT]  = dig_sum;
    res_next                   = (res_sr >> DIGIT) | dig_top;
  end

  // Datapath. Operands are captured only on accept.
  // sum/cout/overflow change only on the last digit, so they hold their
  // value through RUN and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= sub ? ~b : b;
      carry_q <= cin ^ sub;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_sr    <= a_sr >> DIGIT;
      b_sr    <= b_sr >> DIGIT;
      res_sr  <= res_next;
      carry_q <= chain_cout;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_digit) begin
        sum      <= res_next;
        cout     <= chain_cout;
        overflow <= msb_cin ^ chain_cout;
      end
    end
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised multi-cycle adder/subtractor for the adder family. It computes a WIDTH-bit add or subtract DIGIT bits per clock, using a chain of DIGIT full-adder cells and a registered carry between digits. Operands enter through a valid/ready handshake, and the result leaves through a valid/ready handshake. It trades latency for area in datapaths too wide for a single-cycle ripple chain.

Parameters:
WIDTH, 16, operand and result width in bits; must be at least 2.
DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT is the digit count.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands and mode present
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0 = A+B+cin; 1 = A-B-cin
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  raw carry out of MSB
overflow  output  1  two's-complement overflow

Behaviour:
- Reset is a synchronous, active-high rst sampled on clk; it overrides everything.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, internal carry=0, digit counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch the following and go to RUN with counter=0:
    - a into the A shift register.
    - b into the B shift register, or ~b when sub=1.
    - The carry register, set to cin XOR sub.
- RUN:
  - in_ready=0.
  - Each edge adds the low DIGIT bits of the A and B shift registers plus the carry through DIGIT chained full-adder cells.
  - The DIGIT result bits shift into the result register from the MSB side. The A and B registers shift right by DIGIT. The carry register takes the chain carry-out. The counter increments.
  - On the edge processing digit N-1 (the last digit):
    - cout = final chain carry-out.
    - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
    - Go to DONE.
- DONE:
  - out_valid=1, in_ready=0; sum, cout and overflow are held stable.
  - On an edge with out_ready=1, go to IDLE; out_valid falls.
  - With out_ready=0, remain in DONE indefinitely; outputs do not change.
- Latency: out_valid is first high in the cycle after the N-th edge following the accept edge.
  - Throughput is one operation per N+2 cycles minimum (accept, N digit edges, drain).
- Operand immunity: a, b, cin and sub are sampled only at accept. Changes during RUN or DONE have no effect. in_valid outside IDLE is ignored and does not queue.
- Subtract semantics:
  - Subtract computes A + ~B + ~cin.
  - cout=1 means no borrow occurred.
  - The result is always modulo 2^WIDTH.
- Output gating: sum, cout and overflow are undefined-free while out_valid=0. They hold the last computed value (or reset value) and are only meaningful when out_valid=1.
- Reset mid-operation: rst during RUN or DONE discards the operation and returns to the IDLE reset state on that edge. No out_valid pulse is produced.
- Simultaneous rst and in_valid: reset wins; the operands are not accepted.
- DIGIT=WIDTH is legal: N=1, single RUN cycle.

Test Plan:
- WIDTH=8, DIGIT=1; a=0x5A, b=0x3C, cin=0, sub=0 accepted at edge E0 -> out_valid first high after E8; sum=0x96, cout=0, overflow=1.
- WIDTH=8, DIGIT=1; sub=1, a=0x10, b=0x20, cin=0 -> sum=0xF0, cout=0, overflow=0.
- Further WIDTH=8, DIGIT=1 cases:
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, overflow=1.
  - a=0xFF, b=0x00, cin=1, sub=0 -> sum=0x00, cout=1, overflow=0.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid rises, and toggle a, b and in_valid meanwhile -> sum, cout and overflow stay constant; in_ready stays 0; no second accept occurs. When out_ready=1, the next cycle shows in_ready=1 and out_valid=0.
- Reset mid-operation: assert rst for 1 cycle at RUN digit 3 -> next cycle in_ready=1, out_valid=0, sum=0. A following operation 0x01+0x01 yields 0x02 with correct latency.
- WIDTH=16, DIGIT=4; a=0xFFFF, b=0x0001, cin=0, sub=0 -> out_valid after E4; sum=0x0000, cout=1, overflow=0.
- Randomised sweep: random a, b, cin and sub against a reference model, for both configurations.
